fmul_share_arbiter: RTL

- Shares one fp16 floating-point multiplier (cmult-style: EXP/FRA format, 3-bit flag) among NREQ requesters.
- Round-robin arbitration with a per-requester valid/ready handshake.
- Tracks requester IDs through the fixed-latency multiplier pipe.
- Returns results in issue order through a credit-protected response FIFO on a single valid/ready channel tagged with the requester ID.

---
 rtl/fmul_arb_pkg.sv | 15 +
 rtl/rr_arbiter.sv | 64 ++++++
 rtl/fmul_share_arbiter.sv | 127 ++++++++++++
 3 files changed

// File: rtl/fmul_arb_pkg.sv
// Shared constants for the fp16 multiplier share arbiter: default format, flag layout, ID width helper.
package fmul_arb_pkg;
  localparam int EXP_DEF = 5;
  localparam int FRA_DEF = 10;
  localparam int W_DEF   = EXP_DEF + FRA_DEF + 1;
  localparam int FLAG_W  = 3;
  // Flag bit positions as driven by the multiplier; passed through untouched.
  localparam int FLAG_UF = 0;
  localparam int FLAG_OF = 1;
  localparam int FLAG_NV = 2;

  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// One-of-NREQ arbiter: round-robin from a rotating pointer, or fixed lowest-index priority
// when ARB_FIXED_PRIO_EN is defined.
module rr_arbiter import fmul_arb_pkg::*; #(
  parameter int NREQ = 4,
  parameter int IDW  = id_w(NREQ)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  input  logic            en,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_idx,
  output logic            gnt_vld
);
  logic hit;
  int   idx;

`ifdef ARB_FIXED_PRIO_EN
  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ rst_n;

  always_comb begin
    hit = 1'b0;
    idx = 0;
    for (int k = NREQ-1; k >= 0; k--) begin
      if (req[k]) begin
        hit = 1'b1;
        idx = k;
      end
    end
  end
`else
  logic [IDW-1:0] ptr_q, ptr_d;

  // Descending scan so the candidate closest to the pointer is the last one written.
  always_comb begin
    hit = 1'b0;
    idx = 0;
    for (int k = NREQ-1; k >= 0; k--) begin
      if (req[(int'(ptr_q) + k) % NREQ]) begin
        hit = 1'b1;
        idx = (int'(ptr_q) + k) % NREQ;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (gnt_vld) ptr_d = (gnt_idx == IDW'(NREQ-1)) ? '0 : gnt_idx + IDW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end
`endif

  always_comb begin
    gnt_idx = IDW'(idx);
    gnt_vld = en & hit;
    gnt     = '0;
    if (gnt_vld) gnt[gnt_idx] = 1'b1;
  end
endmodule

// File: rtl/fmul_share_arbiter.sv
// Shares one fixed-latency fp16 multiplier among NREQ requesters; results return in issue order
// through a credit-protected FIFO. ARB_FIXED_PRIO_EN selects fixed priority in rr_arbiter.
module fmul_share_arbiter import fmul_arb_pkg::*; #(
  parameter  int EXP       = EXP_DEF,
  parameter  int FRA       = FRA_DEF,
  parameter  int NREQ      = 4,
  parameter  int MUL_LAT   = 2,
  parameter  int RSP_DEPTH = 4,
  localparam int W         = EXP + FRA + 1,
  localparam int IDW       = id_w(NREQ)
) (
  input  logic              clk,
  input  logic              aresetn,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  output logic              mul_valid,
  output logic [W-1:0]      mul_a,
  output logic [W-1:0]      mul_b,
  input  logic [W-1:0]      mul_y,
  input  logic [FLAG_W-1:0] mul_flag,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [W-1:0]      rsp_y,
  output logic [FLAG_W-1:0] rsp_flag,
  output logic [IDW-1:0]    rsp_id
);
  localparam int AW = $clog2(RSP_DEPTH);
  localparam int CW = $clog2(RSP_DEPTH + 1);

  typedef struct packed {
    logic [W-1:0]      y;
    logic [FLAG_W-1:0] flag;
    logic [IDW-1:0]    id;
  } rsp_ent_t;

  logic                         run_q, run_d;
  logic [CW-1:0]                cnt_q, cnt_d;
  logic [MUL_LAT:0]             vld_pipe_q, vld_pipe_d;
  logic [MUL_LAT:0][IDW-1:0]    id_pipe_q, id_pipe_d;
  logic [W-1:0]                 mul_a_q, mul_a_d, mul_b_q, mul_b_d;
  rsp_ent_t [RSP_DEPTH-1:0]     mem_q, mem_d;
  logic [AW:0]                  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic                         arb_en, gnt_vld, wr_en, pop, fifo_full;
  logic [IDW-1:0]               gnt_idx;
  rsp_ent_t                     head;

  // Credit gate only; rsp_ready never reaches req_ready combinationally.
  assign arb_en = run_q && (cnt_q < CW'(RSP_DEPTH));

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .clk     (clk),
    .rst_n   (aresetn),
    .req     (req_valid),
    .en      (arb_en),
    .gnt     (req_ready),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld)
  );

  assign wr_en     = vld_pipe_q[MUL_LAT];
  assign head      = mem_q[rd_ptr_q[AW-1:0]];
  assign rsp_valid = (wr_ptr_q != rd_ptr_q);
  assign pop       = rsp_valid & rsp_ready;
  assign fifo_full = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  always_comb begin
    run_d = 1'b1;
    cnt_d = cnt_q;
    case ({gnt_vld, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
    // Stage 0 is the issue stage itself; stage MUL_LAT lines up with mul_y.
    vld_pipe_d = {vld_pipe_q[MUL_LAT-1:0], gnt_vld};
    id_pipe_d  = {id_pipe_q[MUL_LAT-1:0], gnt_idx};
    mul_a_d    = mul_a_q;
    mul_b_d    = mul_b_q;
    if (gnt_vld) begin
      mul_a_d = req_a[int'(gnt_idx)*W +: W];
      mul_b_d = req_b[int'(gnt_idx)*W +: W];
    end
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_en) begin
      mem_d[wr_ptr_q[AW-1:0]] = '{y: mul_y, flag: mul_flag, id: id_pipe_q[MUL_LAT]};
      wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + (AW+1)'(1);
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      run_q      <= 1'b0;
      cnt_q      <= '0;
      vld_pipe_q <= '0;
      id_pipe_q  <= '0;
      mul_a_q    <= '0;
      mul_b_q    <= '0;
      mem_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      run_q      <= run_d;
      cnt_q      <= cnt_d;
      vld_pipe_q <= vld_pipe_d;
      id_pipe_q  <= id_pipe_d;
      mul_a_q    <= mul_a_d;
      mul_b_q    <= mul_b_d;
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  assign mul_valid = vld_pipe_q[0];
  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign rsp_y     = head.y;
  assign rsp_flag  = head.flag;
  assign rsp_id    = head.id;

  a_no_overflow: assert property (@(posedge clk) disable iff (!aresetn) !(wr_en && fifo_full));
endmodule
